// File: rtl/beat_seq_pkg.sv
// Shared types and constants for the beat sequencer.
package beat_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   localparam int unsigned BPM_MIN  = 40;
   localparam int unsigned BPM_MAX  = 240;
   localparam int unsigned BPM_STEP = 4;
   localparam int unsigned STEPS    = 16;
   localparam int unsigned STEP_W   = $clog2(STEPS);
   localparam int unsigned BPM_W    = 8;

endpackage

// File: rtl/beat_sequencer_tempo_nco.sv
// Tempo phase accumulator: adds bpm each enabled cycle and emits a registered
// tick when the widened sum reaches CLK_HZ*15, keeping the remainder (no drift).
module tempo_nco
   import beat_seq_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             clear,
   input  logic             enable,
   input  logic [BPM_W-1:0] bpm,
   output logic             tick
);

   localparam int unsigned THRESH = CLK_HZ * 15;
   localparam int unsigned AW     = $clog2(THRESH + 255);

   logic [AW-1:0] r_acc;
   logic          r_tick;
   logic [AW:0]   w_sum;
   logic          w_wrap;

   assign w_sum  = {1'b0, r_acc} + (AW+1)'(bpm);
   assign w_wrap = (w_sum >= (AW+1)'(THRESH));

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
      end else if (clear) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
      end else if (enable) begin
         r_acc  <= w_wrap ? AW'(w_sum - (AW+1)'(THRESH)) : AW'(w_sum);
         r_tick <= w_wrap;
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/beat_sequencer.sv
// Step sequencer: run/pause/stop FSM, step counter, tempo and pattern registers.
// Optional BEAT_SEQ_LOOP_LEN_EN adds the loop_len port to set the wrap step.
module beat_sequencer
   import beat_seq_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned BPM_DEFAULT = 120
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              tempo_up,
   input  logic              tempo_down,
   input  logic              edit_toggle,
   input  logic [STEP_W-1:0] edit_idx,
`ifdef BEAT_SEQ_LOOP_LEN_EN
   input  logic [STEP_W-1:0] loop_len,
`endif
   output logic [STEP_W-1:0] currentBeat,
   output logic [STEPS-1:0]  qOut,
   output logic              beat_tick,
   output logic              running,
   output logic [BPM_W-1:0]  bpm
);

   state_t            r_state;
   state_t            w_next_state;
   logic              w_clear;
   logic              w_restart;
   logic              w_nco_tick;
   logic [STEP_W-1:0] w_last;
   logic [STEP_W-1:0] w_beat_next;

   logic [STEP_W-1:0] r_beat;
   logic [STEPS-1:0]  r_pattern;
   logic [BPM_W-1:0]  r_bpm;
   logic              r_tick;
   logic              r_first;
   logic              r_running;

`ifdef BEAT_SEQ_LOOP_LEN_EN
   assign w_last = loop_len;
`else
   assign w_last = STEP_W'(STEPS - 1);
`endif

   // >= so a shrunk loop length wraps a step that is already past it
   assign w_beat_next = (r_beat >= w_last) ? '0 : r_beat + STEP_W'(1);

   always_ff @(posedge clock) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_clear      = 1'b0;
      w_restart    = 1'b0;
      if (stop) begin
         w_next_state = IDLE;
         w_clear      = 1'b1;
      end else if (start) begin
         w_next_state = RUN;
         w_clear      = 1'b1;
         w_restart    = 1'b1;
      end else if (pause) begin
         case (r_state)
            RUN:     w_next_state = PAUSED;
            PAUSED:  w_next_state = RUN;
            default: w_next_state = r_state;
         endcase
      end
   end

   tempo_nco #(.CLK_HZ(CLK_HZ)) u_nco (
      .clock  (clock),
      .resetn (resetn),
      .clear  (w_clear),
      .enable (r_state == RUN),
      .bpm    (r_bpm),
      .tick   (w_nco_tick)
   );

   // Step counter; the cycle after a (re)start emits a tick for step 0 itself
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_beat    <= '0;
         r_tick    <= 1'b0;
         r_first   <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_running <= (w_next_state != IDLE);
         r_tick    <= 1'b0;
         if (w_clear) begin
            r_beat  <= '0;
            r_first <= w_restart;
         end else begin
            r_first <= 1'b0;
            if (r_first) begin
               r_tick <= 1'b1;
            end else if (w_nco_tick) begin
               r_tick <= 1'b1;
               r_beat <= w_beat_next;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_bpm     <= BPM_W'(BPM_DEFAULT);
         r_pattern <= '0;
      end else begin
         if (tempo_up && !tempo_down) begin
            r_bpm <= (r_bpm >= BPM_W'(BPM_MAX - BPM_STEP)) ? BPM_W'(BPM_MAX)
                                                           : r_bpm + BPM_W'(BPM_STEP);
         end else if (tempo_down && !tempo_up) begin
            r_bpm <= (r_bpm <= BPM_W'(BPM_MIN + BPM_STEP)) ? BPM_W'(BPM_MIN)
                                                           : r_bpm - BPM_W'(BPM_STEP);
         end
         if (edit_toggle) begin
            r_pattern[edit_idx] <= ~r_pattern[edit_idx];
         end
      end
   end

   assign currentBeat = r_beat;
   assign qOut        = r_pattern;
   assign beat_tick   = r_tick;
   assign running     = r_running;
   assign bpm         = r_bpm;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer at CLK_HZ=64 (THRESH=960, 8-cycle step at 120 bpm).
module tb_beat_sequencer;

   logic        clock;
   logic        resetn;
   logic        start, stop, pause, tempo_up, tempo_down, edit_toggle;
   logic [3:0]  edit_idx;
   logic [3:0]  currentBeat;
   logic [15:0] qOut;
   logic        beat_tick;
   logic        running;
   logic [7:0]  bpm;
`ifdef BEAT_SEQ_LOOP_LEN_EN
   logic [3:0]  loop_len;
`endif

   int n_cmp = 0;
   int n_err = 0;

   beat_sequencer #(.CLK_HZ(64), .BPM_DEFAULT(120)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .tempo_up    (tempo_up),
      .tempo_down  (tempo_down),
      .edit_toggle (edit_toggle),
      .edit_idx    (edit_idx),
`ifdef BEAT_SEQ_LOOP_LEN_EN
      .loop_len    (loop_len),
`endif
      .currentBeat (currentBeat),
      .qOut        (qOut),
      .beat_tick   (beat_tick),
      .running     (running),
      .bpm         (bpm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        st, sp, pa, up, dn, ed;
      logic [3:0]  idx;
      logic [15:0] q;
      logic [7:0]  bpm;
      logic        run;
   } vec_t;

   vec_t tbl [14];

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(); stop = 1'b0;
   endtask

   // Call right after the start edge; checks tick and step for ncyc edges.
   task automatic run_window(input string nm, input int period, input int ncyc);
      for (int i = 1; i <= ncyc; i++) begin
         cyc();
         chk({nm, "_tick"}, 32'(beat_tick), (i % period == 1) ? 32'd1 : 32'd0);
         chk({nm, "_beat"}, 32'(currentBeat), (i <= period) ? 32'd0 : 32'(((i - 1) / period) % 16));
      end
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      tempo_up = 1'b0; tempo_down = 1'b0; edit_toggle = 1'b0; edit_idx = 4'd0;
`ifdef BEAT_SEQ_LOOP_LEN_EN
      loop_len = 4'd15;
`endif
      //                st sp pa up dn ed idx    q         bpm    run
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd0, 16'h0001, 8'd120, 1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd4, 16'h0011, 8'd120, 1'b0};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd8, 16'h0111, 8'd120, 1'b0};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd12,16'h1111, 8'd120, 1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd4, 16'h1101, 8'd120, 1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,4'd0, 16'h1101, 8'd120, 1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'd0, 16'h1101, 8'd124, 1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'd0, 16'h1101, 8'd120, 1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'd0, 16'h1101, 8'd116, 1'b0};
      tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h1101, 8'd116, 1'b0};
      tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0, 16'h1101, 8'd116, 1'b1};
      tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd0, 16'h1101, 8'd116, 1'b1};
      tbl[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,4'd1, 16'h1103, 8'd116, 1'b1};
      tbl[13] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'd0, 16'h1103, 8'd120, 1'b0};

      // Reset values
      cyc(); cyc();
      chk("rst_q",    32'(qOut), 32'h0);
      chk("rst_bpm",  32'(bpm), 32'd120);
      chk("rst_run",  32'(running), 32'd0);
      chk("rst_beat", 32'(currentBeat), 32'd0);
      chk("rst_tick", 32'(beat_tick), 32'd0);
      resetn = 1'b1;
      cyc();

      // Single-cycle control vectors; step stays 0 throughout
      for (int r = 0; r < 14; r++) begin
         start = tbl[r].st; stop = tbl[r].sp; pause = tbl[r].pa;
         tempo_up = tbl[r].up; tempo_down = tbl[r].dn;
         edit_toggle = tbl[r].ed; edit_idx = tbl[r].idx;
         cyc();
         start = 1'b0; stop = 1'b0; pause = 1'b0;
         tempo_up = 1'b0; tempo_down = 1'b0; edit_toggle = 1'b0;
         chk($sformatf("vec%0d_q", r),    32'(qOut), 32'(tbl[r].q));
         chk($sformatf("vec%0d_bpm", r),  32'(bpm), 32'(tbl[r].bpm));
         chk($sformatf("vec%0d_run", r),  32'(running), 32'(tbl[r].run));
         chk($sformatf("vec%0d_beat", r), 32'(currentBeat), 32'd0);
      end

      // Playback at 120 bpm: tick 1 cycle after the start edge, then every 8, full wrap
      pulse_start();
      chk("start_run",  32'(running), 32'd1);
      chk("start_beat", 32'(currentBeat), 32'd0);
      chk("start_tick", 32'(beat_tick), 32'd0);
      run_window("p120", 8, 8 * 17 + 1);
      pulse_stop();
      chk("stop_run", 32'(running), 32'd0);
      chk("stop_beat", 32'(currentBeat), 32'd0);

      // Tempo saturation
      tempo_up = 1'b1;
      for (int i = 0; i < 21; i++) cyc();
      chk("up21", 32'(bpm), 32'd204);
      for (int i = 0; i < 20; i++) cyc();
      tempo_up = 1'b0;
      chk("up_sat", 32'(bpm), 32'd240);
      tempo_up = 1'b1; tempo_down = 1'b1; cyc();
      tempo_up = 1'b0; tempo_down = 1'b0;
      chk("updn_240", 32'(bpm), 32'd240);
      pulse_start();
      run_window("p240", 4, 4 * 5 + 1);
      pulse_stop();
      tempo_down = 1'b1;
      for (int i = 0; i < 51; i++) cyc();
      tempo_down = 1'b0;
      chk("dn_sat", 32'(bpm), 32'd40);
      tempo_up = 1'b1;
      for (int i = 0; i < 20; i++) cyc();
      tempo_up = 1'b0;
      chk("back_120", 32'(bpm), 32'd120);

      // Pause at step 5 preserves the accumulator phase
      pulse_start();
      for (int i = 1; i <= 41; i++) cyc();
      chk("pre_pause_beat", 32'(currentBeat), 32'd5);
      chk("pre_pause_tick", 32'(beat_tick), 32'd1);
      pause = 1'b1; cyc(); pause = 1'b0;
      chk("pause_run", 32'(running), 32'd1);
      chk("pause_tick0", 32'(beat_tick), 32'd0);
      for (int i = 0; i < 50; i++) begin
         cyc();
         chk("paused_tick", 32'(beat_tick), 32'd0);
         chk("paused_beat", 32'(currentBeat), 32'd5);
      end
      pause = 1'b1; cyc(); pause = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         cyc();
         chk("resume_tick", 32'(beat_tick), (j == 7) ? 32'd1 : 32'd0);
         chk("resume_beat", 32'(currentBeat), (j == 7) ? 32'd6 : 32'd5);
      end

      // start and stop together from RUN: stop wins
      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      chk("ss_run",  32'(running), 32'd0);
      chk("ss_beat", 32'(currentBeat), 32'd0);
      chk("ss_tick", 32'(beat_tick), 32'd0);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("idle_tick", 32'(beat_tick), 32'd0);
      end

      // Reset mid-playback overrides coincident pulses
      tempo_up = 1'b1; cyc(); tempo_up = 1'b0;
      pulse_start();
      for (int i = 0; i < 20; i++) cyc();
      resetn = 1'b0; start = 1'b1; tempo_up = 1'b1; edit_toggle = 1'b1; edit_idx = 4'd3;
      cyc();
      start = 1'b0; tempo_up = 1'b0; edit_toggle = 1'b0;
      chk("mid_rst_q",    32'(qOut), 32'h0);
      chk("mid_rst_bpm",  32'(bpm), 32'd120);
      chk("mid_rst_run",  32'(running), 32'd0);
      chk("mid_rst_beat", 32'(currentBeat), 32'd0);
      chk("mid_rst_tick", 32'(beat_tick), 32'd0);
      resetn = 1'b1;
      cyc();

`ifdef BEAT_SEQ_LOOP_LEN_EN
      // Loop length 3, then shrink to 1 while at step 3
      loop_len = 4'd3;
      pulse_start();
      for (int i = 1; i <= 73; i++) begin
         cyc();
         if (i % 8 == 1) begin
            chk("loop_tick", 32'(beat_tick), 32'd1);
            if (i <= 57)
               chk("loop_beat", 32'(currentBeat), 32'(((i - 1) / 8) % 4));
            else
               chk("shrink_beat", 32'(currentBeat), (i == 65) ? 32'd0 : 32'd1);
         end
         if (i == 57) loop_len = 4'd1;
      end
      pulse_stop();
      loop_len = 4'd15;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
